// File: rtl/vga_layer_mux_pkg.sv
// Shared mode encodings, bar constants and channel-to-RGB replication for the VGA layer mux.
package vga_mux_pkg;

    typedef enum logic [1:0] {
        CAM    = 2'd0,
        CHAN   = 2'd1,
        THRESH = 2'd2,
        MASKED = 2'd3
    } base_mode_t;

    typedef enum logic [1:0] {
        OVL_ALL = 2'd0,
        OVL_ONE = 2'd1,
        SPRITE  = 2'd2,
        TEST    = 2'd3
    } ovl_mode_t;

    localparam int NUM_BARS = 8;
    localparam int MAX_CH_W = 32;

    // Replicates the low ch_w bits of ch into R, G and B; callers truncate to their colour width.
    function automatic logic [3*MAX_CH_W-1:0] rep_rgb(input logic [MAX_CH_W-1:0] ch,
                                                       input int ch_w);
        logic [3*MAX_CH_W-1:0] rgb;
        rgb = '0;
        for (int i = 0; i < MAX_CH_W; i++) begin
            if (i < ch_w) begin
                rgb[i]          = ch[i];
                rgb[ch_w + i]   = ch[i];
                rgb[2*ch_w + i] = ch[i];
            end
        end
        return rgb;
    endfunction

endpackage

// File: rtl/vga_layer_mux_test_pattern.sv
// Colour-bar generator; counters run whenever active_in is high so the pattern stays phase-correct.
module vga_test_pattern
    import vga_mux_pkg::*;
#(
    parameter int COLOR_W = 12,
    parameter int BAR_W   = 80
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               active_in,
    output logic [COLOR_W-1:0] color_out
);
    localparam int CH_W  = COLOR_W / 3;
    localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int IDX_W = $clog2(NUM_BARS);

    logic [SUB_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic [IDX_W-1:0]   bar_idx_q, bar_idx_d;
    logic [IDX_W-1:0]   bar_inv;
    logic [COLOR_W-1:0] color_q, color_d;

    always_comb begin
        sub_cnt_d = '0;
        bar_idx_d = '0;
        if (active_in) begin
            if (sub_cnt_q == SUB_W'(BAR_W - 1)) begin
                sub_cnt_d = '0;
                bar_idx_d = bar_idx_q + 1'b1;
            end else begin
                sub_cnt_d = sub_cnt_q + 1'b1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    // Bar 0 is white and bar 7 black, so the colour bits are the inverted index.
    assign bar_inv = ~bar_idx_q;
    assign color_d = {{CH_W{bar_inv[2]}}, {CH_W{bar_inv[1]}}, {CH_W{bar_inv[0]}}};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_cnt_q <= '0;
            bar_idx_q <= '0;
            color_q   <= '0;
        end else begin
            sub_cnt_q <= sub_cnt_d;
            bar_idx_q <= bar_idx_d;
            color_q   <= color_d;
        end
    end

    assign color_out = color_q;

endmodule

// File: rtl/vga_layer_mux.sv
// Two-stage VGA compositor: base layer in stage 1, overlay/sprite/test pattern and blanking in stage 2.
module vga_layer_mux
    import vga_mux_pkg::*;
#(
    parameter int COLOR_W    = 12,
    parameter int NUM_MASKS  = 3,
    parameter int NUM_OVL    = 4,
    parameter int BLINK_LOG2 = 4,
    parameter int BAR_W      = 80
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           new_frame_in,
    input  logic [3:0]                     sel_in,
    input  logic                           active_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic [COLOR_W-1:0]             camera_pixel_in,
    input  logic [COLOR_W/3-1:0]           camera_y_in,
    input  logic [COLOR_W/3-1:0]           channel_in,
    input  logic [NUM_MASKS-1:0]           mask_in,
    input  logic [NUM_MASKS*COLOR_W-1:0]   mask_color_in,
    input  logic [NUM_OVL-1:0]             ovl_hit_in,
    input  logic [NUM_OVL-1:0]             ovl_blink_in,
    input  logic [NUM_OVL*COLOR_W-1:0]     ovl_color_in,
    input  logic [COLOR_W-1:0]             sprite_pixel_in,
    output logic [COLOR_W-1:0]             pixel_out,
    output logic                           hsync_out,
    output logic                           vsync_out,
    output logic                           active_out,
    output logic [3:0]                     sel_active_out
);
    localparam int CH_W = COLOR_W / 3;
    localparam int FC_W = BLINK_LOG2 + 1;

    if (COLOR_W % 3 != 0) begin : g_bad_color_w
        $error("COLOR_W must be a multiple of 3");
    end

    logic [3:0]      sel_q;
    logic [FC_W-1:0] frame_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_q       <= '0;
            frame_cnt_q <= '0;
        end else if (new_frame_in) begin
            sel_q       <= sel_in;
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign sel_active_out = sel_q;

    logic [COLOR_W-1:0] tp_color;

    vga_test_pattern #(
        .COLOR_W (COLOR_W),
        .BAR_W   (BAR_W)
    ) u_test_pattern (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .active_in (active_in),
        .color_out (tp_color)
    );

    logic [COLOR_W-1:0] chan_rgb, luma_rgb, masked_rgb, base_d;

    assign chan_rgb = COLOR_W'(rep_rgb(MAX_CH_W'(channel_in), CH_W));
    assign luma_rgb = COLOR_W'(rep_rgb(MAX_CH_W'(camera_y_in), CH_W));

    always_comb begin
        masked_rgb = luma_rgb;
        for (int k = NUM_MASKS - 1; k >= 0; k--) begin
            if (mask_in[k]) masked_rgb = mask_color_in[k*COLOR_W +: COLOR_W];
        end
        case (base_mode_t'(sel_q[1:0]))
            CAM:     base_d = camera_pixel_in;
            CHAN:    base_d = chan_rgb;
            THRESH:  base_d = mask_in[0] ? '1 : '0;
            MASKED:  base_d = masked_rgb;
            default: base_d = camera_pixel_in;
        endcase
    end

    // ---- stage 1 boundary: base result plus everything stage 2 needs, tagged with its mode ----
    logic [COLOR_W-1:0]         base_p1_q, sprite_p1_q;
    ovl_mode_t                  omode_p1_q;
    logic                       blink_ok_p1_q, act_p1_q, hs_p1_q, vs_p1_q;
    logic [NUM_OVL-1:0]         hit_p1_q, blink_p1_q;
    logic [NUM_OVL*COLOR_W-1:0] ovl_color_p1_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            base_p1_q      <= '0;
            sprite_p1_q    <= '0;
            omode_p1_q     <= OVL_ALL;
            blink_ok_p1_q  <= 1'b0;
            act_p1_q       <= 1'b0;
            hs_p1_q        <= 1'b0;
            vs_p1_q        <= 1'b0;
            hit_p1_q       <= '0;
            blink_p1_q     <= '0;
            ovl_color_p1_q <= '0;
        end else begin
            base_p1_q      <= base_d;
            sprite_p1_q    <= sprite_pixel_in;
            omode_p1_q     <= ovl_mode_t'(sel_q[3:2]);
            blink_ok_p1_q  <= ~frame_cnt_q[BLINK_LOG2];
            act_p1_q       <= active_in;
            hs_p1_q        <= hsync_in;
            vs_p1_q        <= vsync_in;
            hit_p1_q       <= ovl_hit_in;
            blink_p1_q     <= ovl_blink_in;
            ovl_color_p1_q <= ovl_color_in;
        end
    end

    logic [NUM_OVL-1:0] vis;
    logic               any_vis;
    logic [COLOR_W-1:0] ovl_rgb, pix_d;

    assign vis = hit_p1_q & (~blink_p1_q | {NUM_OVL{blink_ok_p1_q}});

    always_comb begin
        any_vis = 1'b0;
        ovl_rgb = '0;
        for (int k = NUM_OVL - 1; k >= 0; k--) begin
            if (vis[k]) begin
                any_vis = 1'b1;
                ovl_rgb = ovl_color_p1_q[k*COLOR_W +: COLOR_W];
            end
        end
        case (omode_p1_q)
            OVL_ALL: pix_d = any_vis ? ovl_rgb : base_p1_q;
            OVL_ONE: pix_d = vis[0] ? ovl_color_p1_q[COLOR_W-1:0] : base_p1_q;
            SPRITE:  pix_d = (sprite_p1_q != '0) ? sprite_p1_q : base_p1_q;
            TEST:    pix_d = tp_color;
            default: pix_d = base_p1_q;
        endcase
        if (!act_p1_q) pix_d = '0;
    end

    // ---- stage 2 boundary: registered outputs ----
    logic [COLOR_W-1:0] pix_q;
    logic               hs_q, vs_q, act_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            act_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            hs_q  <= hs_p1_q;
            vs_q  <= vs_p1_q;
            act_q <= act_p1_q;
        end
    end

    assign pixel_out  = pix_q;
    assign hsync_out  = hs_q;
    assign vsync_out  = vs_q;
    assign active_out = act_q;

endmodule

// File: tb/tb_vga_layer_mux.sv
// Scoreboard bench for vga_layer_mux: directed scenarios then randomized traffic against a reference model.
module tb_vga_layer_mux;
    localparam int COLOR_W    = 12;
    localparam int NUM_MASKS  = 3;
    localparam int NUM_OVL    = 4;
    localparam int BLINK_LOG2 = 4;
    localparam int BAR_W      = 80;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        new_frame_in;
    logic [3:0]  sel_in;
    logic        active_in, hsync_in, vsync_in;
    logic [11:0] camera_pixel_in;
    logic [3:0]  camera_y_in, channel_in;
    logic [2:0]  mask_in;
    logic [35:0] mask_color_in;
    logic [3:0]  ovl_hit_in, ovl_blink_in;
    logic [47:0] ovl_color_in;
    logic [11:0] sprite_pixel_in;
    logic [11:0] pixel_out;
    logic        hsync_out, vsync_out, active_out;
    logic [3:0]  sel_active_out;

    vga_layer_mux #(
        .COLOR_W(COLOR_W), .NUM_MASKS(NUM_MASKS), .NUM_OVL(NUM_OVL),
        .BLINK_LOG2(BLINK_LOG2), .BAR_W(BAR_W)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .new_frame_in(new_frame_in), .sel_in(sel_in),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .camera_pixel_in(camera_pixel_in), .camera_y_in(camera_y_in), .channel_in(channel_in),
        .mask_in(mask_in), .mask_color_in(mask_color_in), .ovl_hit_in(ovl_hit_in),
        .ovl_blink_in(ovl_blink_in), .ovl_color_in(ovl_color_in), .sprite_pixel_in(sprite_pixel_in),
        .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .active_out(active_out), .sel_active_out(sel_active_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          due;
        logic [11:0] pix;
        logic        hs, vs, act;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_sel = 0, m_fcnt = 0, m_run = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, want);
        end
    endtask

    // Reference model: the composited pixel for the inputs currently driven, given the committed mode.
    function automatic logic [11:0] model_pix();
        logic [11:0] base, pix;
        int          bsel, osel, bar, v;
        logic        blink_off, found;
        bsel = m_sel % 4;
        osel = (m_sel / 4) % 4;
        blink_off = ((m_fcnt >> BLINK_LOG2) % 2) == 1;
        case (bsel)
            0: base = camera_pixel_in;
            1: base = {3{channel_in}};
            2: base = mask_in[0] ? 12'hFFF : 12'h000;
            default: begin
                base = {3{camera_y_in}};
                found = 1'b0;
                for (int k = 0; k < NUM_MASKS; k++)
                    if (!found && mask_in[k]) begin
                        base = mask_color_in[k*12 +: 12];
                        found = 1'b1;
                    end
            end
        endcase
        pix = base;
        case (osel)
            0: begin
                found = 1'b0;
                for (int k = 0; k < NUM_OVL; k++)
                    if (!found && ovl_hit_in[k] && (!ovl_blink_in[k] || !blink_off)) begin
                        pix = ovl_color_in[k*12 +: 12];
                        found = 1'b1;
                    end
            end
            1: if (ovl_hit_in[0] && (!ovl_blink_in[0] || !blink_off)) pix = ovl_color_in[11:0];
            2: if (sprite_pixel_in != 12'h000) pix = sprite_pixel_in;
            default: begin
                bar = (m_run / BAR_W) % 8;
                v = 7 - bar;
                pix = {(v[2] ? 4'hF : 4'h0), (v[1] ? 4'hF : 4'h0), (v[0] ? 4'hF : 4'h0)};
            end
        endcase
        if (!active_in) pix = 12'h000;
        return pix;
    endfunction

    // Issue one pixel: queue its expected output, advance the model, clock it in.
    task automatic step();
        exp_t e;
        e.due = cyc + 2;
        e.pix = model_pix();
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        e.act = active_in;
        sb.push_back(e);
        if (new_frame_in) begin
            m_sel  = int'(sel_in);
            m_fcnt = m_fcnt + 1;
        end
        m_run = active_in ? m_run + 1 : 0;
        @(posedge clk_in);
        #1;
        chk("sel_active", 32'(sel_active_out), 32'(m_sel[3:0]));
    endtask

    task automatic commit(input logic [3:0] s);
        sel_in = s;
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
    endtask

    task automatic randomize_inputs();
        sel_in          = 4'($urandom);
        new_frame_in    = ($urandom_range(0, 39) == 0);
        active_in       = ($urandom_range(0, 19) != 0);
        hsync_in        = 1'($urandom);
        vsync_in        = 1'($urandom);
        camera_pixel_in = 12'($urandom);
        camera_y_in     = 4'($urandom);
        channel_in      = 4'($urandom);
        mask_in         = 3'($urandom);
        mask_color_in   = 36'({$urandom(), $urandom()});
        ovl_hit_in      = 4'($urandom);
        ovl_blink_in    = 4'($urandom);
        ovl_color_in    = 48'({$urandom(), $urandom()});
        sprite_pixel_in = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix"}, 32'(pixel_out), 32'h0);
        chk({tag, "_hs"}, 32'(hsync_out), 32'h0);
        chk({tag, "_vs"}, 32'(vsync_out), 32'h0);
        chk({tag, "_act"}, 32'(active_out), 32'h0);
        chk({tag, "_sel"}, 32'(sel_active_out), 32'h0);
    endtask

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.due < cyc) begin
                    chk("sb_stale", 32'(cyc), 32'(mon_e.due));
                end else begin
                    chk("pixel", 32'(pixel_out), 32'(mon_e.pix));
                    chk("hsync", 32'(hsync_out), 32'(mon_e.hs));
                    chk("vsync", 32'(vsync_out), 32'(mon_e.vs));
                    chk("active", 32'(active_out), 32'(mon_e.act));
                end
            end
        end
    end

    initial begin
        rst_n_in = 1'b0;
        randomize_inputs();
        new_frame_in = 1'b1;
        active_in = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        sel_in = 4'b0110;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        new_frame_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Camera passthrough with sync delay matching
        sel_in = 4'b0000; active_in = 1'b1; camera_pixel_in = 12'h123;
        ovl_hit_in = 4'b0000; sprite_pixel_in = 12'h000;
        hsync_in = 1'b1; vsync_in = 1'b0; step();
        hsync_in = 1'b0; vsync_in = 1'b1; step();
        hsync_in = 1'b1; vsync_in = 1'b1; step();

        // Mid-frame select change is shadowed until the frame pulse
        sel_in = 4'b0010; mask_in = 3'b001;
        repeat (3) step();
        new_frame_in = 1'b1; step(); new_frame_in = 1'b0;
        mask_in = 3'b001; step();
        mask_in = 3'b000; step();

        // Mask priority and luma fallback
        commit(4'b0011);
        mask_in = 3'b110; mask_color_in = {12'h25E, 12'h5C9, 12'h777}; step();
        mask_in = 3'b000; camera_y_in = 4'hA; step();

        // Overlay priority and blinking across frame-counter rollover
        commit(4'b0000);
        ovl_hit_in = 4'b0101; ovl_blink_in = 4'b0001;
        ovl_color_in = {12'h111, 12'h0FF, 12'h222, 12'h0F0};
        step();
        for (int f = 0; f < 34; f++) begin
            new_frame_in = 1'b1; step(); new_frame_in = 1'b0;
            step();
        end
        commit(4'b0100);
        repeat (2) step();

        // Colour bars across a full 640-pixel line, then blanking
        active_in = 1'b0;
        commit(4'b1100);
        step();
        active_in = 1'b1;
        repeat (640) step();
        active_in = 1'b0;
        repeat (2) step();
        active_in = 1'b1;
        repeat (90) step();

        // Sprite transparency
        commit(4'b1000);
        camera_pixel_in = 12'h456; sprite_pixel_in = 12'h000; step();
        sprite_pixel_in = 12'h0A0; step();

        for (int i = 0; i < 2500; i++) begin
            randomize_inputs();
            step();
        end

        // Asynchronous reset mid-frame clears the pipeline immediately
        #2;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        m_sel = 0; m_fcnt = 0; m_run = 0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            step();
        end

        new_frame_in = 1'b0;
        for (int w = 0; w < 8 && sb.size() > 0; w++) @(posedge clk_in);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_layer_mux.md
Name: vga_layer_mux

Overview:
Parametrised, pipelined successor to the combinational VGA pixel mux. It composites a base video layer (camera, channel grayscale, threshold b/w, or masked luma) with N prioritised overlay layers, a sprite layer, or a built-in colour-bar test pattern. The mode select is shadow-registered and committed only at frame start. Syncs and data-enable are delay-matched to the pixel. It sits between the pixel-processing pipeline and the VGA/HDMI output encoder.

Parameters:
COLOR_W, 12, packed RGB width; must be a multiple of 3; CH_W = COLOR_W/3.
NUM_MASKS, 3, number of threshold mask inputs used in masked-luma mode.
NUM_OVL, 4, number of overlay layers; index 0 has the highest priority.
BLINK_LOG2, 4, blinking overlays are visible while frame_cnt[BLINK_LOG2] == 0.
BAR_W, 80, width of each test-pattern bar in active pixels.

Ports:
clk_in  in  1  pixel clock
rst_n_in  in  1  asynchronous, active-low reset
new_frame_in  in  1  single-cycle frame-start pulse
sel_in  in  4  requested mode: [1:0] base, [3:2] overlay
active_in  in  1  data enable for the current pixel
hsync_in, vsync_in  in  1 each  raw syncs
camera_pixel_in  in  COLOR_W  camera RGB
camera_y_in, channel_in  in  CH_W each  luma / selected channel
mask_in  in  NUM_MASKS  threshold masks; bit 0 also drives b/w mode
mask_color_in  in  NUM_MASKS*COLOR_W  colour per mask, mask k at [k*COLOR_W +: COLOR_W]
ovl_hit_in  in  NUM_OVL  overlay coverage for this pixel
ovl_blink_in  in  NUM_OVL  per-overlay blink enable
ovl_color_in  in  NUM_OVL*COLOR_W  overlay colours, packed like mask_color_in
sprite_pixel_in  in  COLOR_W  sprite pixel; 0 means transparent
pixel_out  out  COLOR_W  composited pixel
hsync_out, vsync_out, active_out  out  1 each  syncs and enable, delayed to match pixel_out
sel_active_out  out  4  currently committed mode

Behaviour:
- Reset (asynchronous, active-low): sel_q=0, frame_cnt=0, all pipeline registers 0. All outputs are 0 until the first clock after release.
- Mode commit:
  - If new_frame_in=1, sel_q <= sel_in and frame_cnt <= frame_cnt+1 (wraps).
  - Otherwise sel_q holds. Changes to sel_in mid-frame are ignored.
  - sel_active_out = sel_q.
- Fixed latency of 2 cycles for every output (pixel, syncs, active).
- Mode coherence: each pixel carries the sel_q value it sampled at stage 1 down the pipe. A commit therefore applies to input pixels presented on the cycle after the new_frame_in pulse, and never splits a pixel across modes.
- Stage 1, base layer by sel[1:0]:
  - 00: camera_pixel_in.
  - 01: channel_in replicated to R, G and B.
  - 10: all-ones if mask_in[0]=1, else 0.
  - 11: mask_color of the lowest-index set mask; if none is set, camera_y_in replicated.
- Stage 2, overlay by sel[3:2]:
  - 00: colour of the lowest-index overlay k with ovl_hit_in[k]=1 and (ovl_blink_in[k]=0 or frame_cnt[BLINK_LOG2]=0); otherwise the base layer.
  - 01: overlay 0 only, same blink rule.
  - 10: sprite_pixel_in if nonzero, otherwise the base layer.
  - 11: test pattern.
- Overlay and sprite inputs are sampled at stage 1 and registered alongside the base result.
- Test pattern:
  - Counters: bar_idx (3b) and sub_cnt (count 0..BAR_W-1). Both reset to 0 on any cycle where active_in=0.
  - While active_in=1, sub_cnt increments. On sub_cnt==BAR_W-1, sub_cnt returns to 0 and bar_idx increments, wrapping 7→0.
  - Bar colour for bar b: R = all-ones if b[2], G = all-ones if b[1], B = all-ones if b[0]. b is inverted so bar 0 is white and bar 7 is black.
  - The counters run regardless of mode, so the pattern is phase-correct when switching into mode 11.
- Blanking: if the delayed active is 0, pixel_out = 0 regardless of mode.
- Simultaneous new_frame_in and sel_in change: the sel_in value on the pulse cycle is taken.
- Reset asserted mid-frame: the pipeline clears immediately; outputs read 0 until valid data re-propagates 2 cycles after the first post-reset input.

Decomposition:
- Package vga_mux_pkg:
  - enums base_mode_t (CAM, CHAN, THRESH, MASKED) and ovl_mode_t (OVL_ALL, OVL_ONE, SPRITE, TEST);
  - function for CH_W replication to RGB;
  - test-pattern bar count constant (8).
- One sub-module, vga_test_pattern: the bar_idx/sub_cnt counters and bar colour, registered to align with stage 1.

Test Plan:
1. Reset and commit: hold rst_n_in=0 → all outputs 0. Release, set sel_in=4'b0000, active_in=1, camera_pixel_in=12'h123 → pixel_out=12'h123 exactly 2 cycles later, with hsync/vsync/active delayed by the same 2 cycles.
2. Shadow select: change sel_in to 4'b0010 mid-frame → output stays camera. Pulse new_frame_in → the first pixel after the pulse outputs 12'hFFF with mask_in[0]=1 and 12'h000 with mask_in[0]=0. sel_active_out=4'b0010.
3. Mask priority: sel=4'b0011, mask_in=3'b110, mask_color1=12'h5C9, mask_color2=12'h25E → 12'h5C9. With mask_in=0 and camera_y_in=4'hA → 12'hAAA.
4. Overlay priority and blink: sel=4'b0000, ovl_hit_in=4'b0101, ovl_blink_in=4'b0001, colours 12'h0F0 / 12'h0FF → 12'h0F0 while frame_cnt[4]=0. After 16 frames (frame_cnt[4]=1) → 12'h0FF.
5. Test pattern: sel=4'b1100, 640-cycle active run, BAR_W=80 → pixel 0 = 12'hFFF, pixel 80 = 12'hFF0, pixel 559 = 12'h00F, pixel 560 = 12'h000. active_in=0 resets the bars; active_out=0 forces 0.
6. Sprite: sel=4'b1000, sprite=12'h000 → base layer passes through; sprite=12'h0A0 → 12'h0A0.
